imem_boot_loader: RTL
=====================

# imem_boot_loader

Boot-time program loader that is the write side of the instruction memory the single-cycle core fetches from. Accepts a framed byte stream (word count, little-endian instruction words, optional checksum), packs bytes into 32-bit words, writes them to consecutive instruction-memory addresses from 0, and holds the core in reset until the image is complete. Sits between the host byte source (UART receiver or bench driver) and the instruction memory write port / core reset.

## Interface

Parameters:
- ADDR_W, 8: instruction-memory word-address width.
- IMEM_DEPTH, 256: number of writable words; must satisfy IMEM_DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_valid  input  1  byte available on rx_data.
- rx_data  input  8  incoming byte.
- rx_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  word to write.
- core_reset  output  1  reset to the core; high until a successful load.
- load_done  output  1  image loaded, core released.
- load_error  output  1  frame rejected, core held.

## Operation

- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, load_done=0, load_error=0; state LEN_LO; byte counter 0; checksum 0.
- Byte accepted only when rx_valid && rx_ready. rx_ready=1 in LEN_LO, LEN_HI, DATA, CSUM; 0 in WRITE, DONE, ERROR.
- States:
  - LEN_LO: accept N[7:0] -> LEN_HI.
  - LEN_HI: accept N[15:8]; N==0 -> DONE (CSUM when checksum compiled in); N > IMEM_DEPTH -> ERROR; else DATA.
  - DATA: bytes 0..3 of a word fill bits [7:0],[15:8],[23:16],[31:24]; on 4th byte -> WRITE.
  - WRITE: one cycle; imem_we=1, imem_wdata=packed word, imem_addr=current address; address += 1, words-remaining -= 1; remaining==0 -> DONE (or CSUM), else DATA.
  - DONE: core_reset=0, load_done=1; terminal until reset.
  - ERROR: core_reset=1, load_error=1; terminal until reset; further bytes not accepted.
- Address arithmetic ADDR_W bits; never wraps because N <= IMEM_DEPTH is enforced.
- Reset mid-load: returns to LEN_LO, address 0, core_reset=1; already-written memory words are not cleared.
- rx_valid high in WRITE/DONE/ERROR: byte is not consumed (rx_ready=0); source must hold it.

## Timing

- imem_we asserts the cycle after the 4th byte of a word is accepted, for exactly one cycle.
- Peak throughput: 4 bytes per 5 cycles.
- DONE entered the cycle after the last WRITE (no checksum) or after the checksum byte is accepted; core_reset falls and load_done rises on the same edge.
- Outputs are registered; no combinational path from rx_valid to rx_ready.

## Configuration

- IMEM_LOADER_CHECKSUM_EN defined: CSUM state compiled in; running 8-bit sum (mod 256) of all data bytes (length bytes excluded); after the last word (or immediately when N==0) one checksum byte is accepted; equal -> DONE, unequal -> ERROR.
- Not defined: no CSUM state or checksum register; last WRITE (or N==0) goes straight to DONE.

## Structure

- Shared package imem_loader_pkg: state enum (LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERROR), BYTES_PER_WORD=4, LEN_BYTES=2.
- One sub-module: word_packer (byte-lane shift into 32-bit word, 2-bit lane counter, word_full flag, clear input).

## Test plan

- Reset, then frame N=2, bytes 13 05 00 00, 93 05 15 00 -> writes 0x00000513 @0, 0x00150593 @1; core_reset falls after 2nd write; load_done=1.
- N=0 frame (00 00) -> no imem_we, load_done=1 (with checksum: byte 00 required first).
- N=IMEM_DEPTH+1 (01 01 at default) -> ERROR, load_error=1, core_reset=1, rx_ready stays 0.
- rx_valid toggled every other cycle during N=3 load -> same three words at addresses 0..2, no byte lost or duplicated.
- reset asserted after 6 data bytes of an N=4 frame -> all outputs return to reset values; fresh N=1 frame then writes @0 correctly.
- With IMEM_LOADER_CHECKSUM_EN: N=1, 01 02 03 04, checksum 0A -> DONE; checksum 0B -> ERROR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Optional checksum feature is selected with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef logic [2:0] loader_state_t;

    localparam loader_state_t LEN_LO = 3'd0;
    localparam loader_state_t LEN_HI = 3'd1;
    localparam loader_state_t DATA   = 3'd2;
    localparam loader_state_t WRITE  = 3'd3;
    localparam loader_state_t CSUM   = 3'd4;
    localparam loader_state_t DONE   = 3'd5;
    localparam loader_state_t ERROR  = 3'd6;

    // States in which the loader consumes a byte from the host.
    function automatic logic state_accepts(loader_state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// Little-endian byte-to-word packer: bytes shift in from the top so the
// first byte ends up in [7:0]; word_full pulses the cycle after byte 4.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic [31:0]       word,
    output logic [LANE_W-1:0] lane,
    output logic              word_full
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word      <= '0;
            lane      <= '0;
            word_full <= 1'b0;
        end else begin
            word_full <= byte_valid && (lane == LANE_W'(BYTES_PER_WORD - 1));
            if (byte_valid) begin
                word <= {byte_data, word[31:8]};
                lane <= lane + LANE_W'(1);
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader writing instruction memory from address 0 and
// holding the core in reset until the image is in. Checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int IMEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t TAIL = CSUM;
`else
    localparam loader_state_t TAIL = DONE;
`endif

    loader_state_t     state, state_nxt;
    logic [7:0]        len_lo;
    logic [15:0]       words_left;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic [15:0]       len_full;
    logic              len_too_big;
    logic              pk_clear, pk_valid, pk_full;
    logic [31:0]       pk_word;
    logic [LANE_W-1:0] pk_lane;

    assign accept      = rx_valid && rx_ready;
    assign len_full    = {rx_data, len_lo};
    assign len_too_big = {1'b0, len_full} > 17'(IMEM_DEPTH);
    assign pk_clear    = (state == LEN_HI) && accept;
    assign pk_valid    = (state == DATA) && accept;

    word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_data  (rx_data),
        .word       (pk_word),
        .lane       (pk_lane),
        .word_full  (pk_full)
    );

    // The packer's register holds the word stable through WRITE, and its
    // word_full flag is high for exactly that cycle.
    assign imem_we    = pk_full;
    assign imem_wdata = pk_word;
    assign imem_addr  = addr;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (reset || pk_clear)
            csum <= '0;
        else if (pk_valid)
            csum <= csum + rx_data;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            LEN_LO: if (accept) state_nxt = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (len_full == 16'd0)
                        state_nxt = TAIL;
                    else if (len_too_big)
                        state_nxt = ERROR;
                    else
                        state_nxt = DATA;
                end
            end
            DATA: begin
                if (accept && (pk_lane == LANE_W'(BYTES_PER_WORD - 1)))
                    state_nxt = WRITE;
            end
            WRITE: state_nxt = (words_left == 16'd1) ? TAIL : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept)
                    state_nxt = (rx_data == csum) ? DONE : ERROR;
            end
`endif
            default: state_nxt = state;
        endcase
    end

    // Status outputs are registered from the next state so they change on
    // the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LEN_LO;
            len_lo     <= '0;
            words_left <= '0;
            addr       <= '0;
            rx_ready   <= 1'b0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state      <= state_nxt;
            rx_ready   <= state_accepts(state_nxt);
            core_reset <= (state_nxt != DONE);
            load_done  <= (state_nxt == DONE);
            load_error <= (state_nxt == ERROR);
            if ((state == LEN_LO) && accept)
                len_lo <= rx_data;
            if (pk_clear)
                words_left <= len_full;
            if (state == WRITE) begin
                addr       <= addr + ADDR_W'(1);
                words_left <= words_left - 16'd1;
            end
        end
    end

endmodule
